// File: rtl/icosoc_eventbuf_pkg.sv
// rtl/icosoc_eventbuf_pkg.sv - shared constants for the pin-change event buffer
package icosoc_eventbuf_pkg;

  localparam int TS_WIDTH = 32;

  // Register byte offsets on the ctrl bus
  localparam logic [15:0] REG_CTRL      = 16'h0000;
  localparam logic [15:0] REG_MASK      = 16'h0004;
  localparam logic [15:0] REG_STATUS    = 16'h0008;
  localparam logic [15:0] REG_HEAD_TS   = 16'h000C;
  localparam logic [15:0] REG_HEAD_DATA = 16'h0010;
  localparam logic [15:0] REG_DROPS     = 16'h0014;

  // CTRL bits
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  // STATUS bits above the 16-bit level field
  localparam int STATUS_EMPTY_BIT    = 16;
  localparam int STATUS_FULL_BIT     = 17;
  localparam int STATUS_OVERFLOW_BIT = 18;

  // A record is {timestamp, pin value}
  function automatic int rec_width(input int io_width);
    return TS_WIDTH + io_width;
  endfunction

endpackage

// File: rtl/icosoc_eventbuf_fifo.sv
// rtl/icosoc_eventbuf_fifo.sv - sync FIFO with registered-read storage and prefetched head
module icosoc_eventbuf_fifo #(
  parameter int WIDTH      = 40,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_MAX   = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      head_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (level_q == LVL_MAX);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = head_q;

  // Full/empty are judged on the pre-edge level, so a pop never makes room for a same-cycle push
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Read pointer as it will be after this edge; drives the registered read address
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      rd_ptr_nxt = '0;
    end else if (do_pop) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Head prefetch: registered read of the next head, bypassing a record written into that slot this edge
  always_ff @(posedge clk) begin
    if (do_push && (wr_ptr == rd_ptr_nxt)) begin
      head_q <= wdata;
    end else begin
      head_q <= mem[rd_ptr_nxt];
    end
  end

  // Pointers and level
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LVL_ONE;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LVL_ONE;
      end
    end
  end

endmodule

// File: rtl/icosoc_mod_eventbuf.sv
// rtl/icosoc_mod_eventbuf.sv - pin-change event recorder with timestamped FIFO and ctrl bus
module icosoc_mod_eventbuf
  import icosoc_eventbuf_pkg::*;
#(
  parameter int IO_WIDTH   = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [3:0]          ctrl_wr,
  input  logic                ctrl_rd,
  input  logic [15:0]         ctrl_addr,
  input  logic [31:0]         ctrl_wdat,
  output logic [31:0]         ctrl_rdat,
  output logic                ctrl_done,
  input  logic [IO_WIDTH-1:0] io_in,
  input  logic [31:0]         timestamp,
  output logic                nonempty
);

  localparam int REC_W = rec_width(IO_WIDTH);

  logic                ctrl_en;
  logic [IO_WIDTH-1:0] mask_q;
  logic [IO_WIDTH-1:0] prev_q;
  logic [15:0]         drop_cnt;
  logic                overflow_q;

  logic                access;
  logic                is_wr;
  logic                wr_acc;
  logic                rd_acc;
  logic                clear;
  logic                evt;
  logic                push;
  logic                pop;
  logic [31:0]         rd_val;

  logic [REC_W-1:0]    head;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;

  logic                unused_wdat;
  assign unused_wdat = ^ctrl_wdat;

  assign access = (ctrl_rd || (|ctrl_wr)) && !ctrl_done;
  assign is_wr  = |ctrl_wr;
  assign wr_acc = access && is_wr;
  assign rd_acc = access && !is_wr;

  // Clear beats a coincident event: the event is neither stored nor counted
  assign clear = wr_acc && (ctrl_addr == REG_CTRL) && ctrl_wdat[CTRL_CLEAR_BIT];
  assign evt   = ctrl_en && (|((io_in ^ prev_q) & mask_q));
  assign push  = evt && !clear;
  assign pop   = rd_acc && (ctrl_addr == REG_HEAD_DATA) && !empty;

  assign nonempty = !empty;

  icosoc_eventbuf_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (clear),
    .wdata  ({timestamp, io_in}),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // Previous-sample tracking runs regardless of enable; CTRL/MASK register writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_q  <= '0;
      ctrl_en <= 1'b0;
      mask_q  <= '0;
    end else begin
      prev_q <= io_in;
      if (wr_acc && (ctrl_addr == REG_CTRL)) begin
        ctrl_en <= ctrl_wdat[CTRL_ENABLE_BIT];
      end
      if (wr_acc && (ctrl_addr == REG_MASK)) begin
        mask_q <= ctrl_wdat[IO_WIDTH-1:0];
      end
    end
  end

  // Saturating drop counter and sticky overflow for events that hit a full FIFO
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      drop_cnt   <= '0;
      overflow_q <= 1'b0;
    end else if (evt && full) begin
      overflow_q <= 1'b1;
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Read data mux for the register map
  always_comb begin
    rd_val = '0;
    case (ctrl_addr)
      REG_CTRL:      rd_val[CTRL_ENABLE_BIT] = ctrl_en;
      REG_MASK:      rd_val = 32'(mask_q);
      REG_STATUS: begin
        rd_val[15:0]                = 16'(level);
        rd_val[STATUS_EMPTY_BIT]    = empty;
        rd_val[STATUS_FULL_BIT]     = full;
        rd_val[STATUS_OVERFLOW_BIT] = overflow_q;
      end
      REG_HEAD_TS:   rd_val = empty ? 32'd0 : head[REC_W-1:IO_WIDTH];
      REG_HEAD_DATA: rd_val = empty ? 32'd0 : 32'(head[IO_WIDTH-1:0]);
      REG_DROPS:     rd_val[15:0] = drop_cnt;
      default:       rd_val = '0;
    endcase
  end

  // One-cycle acknowledge with read data valid only in the done cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end else begin
      ctrl_done <= access;
      ctrl_rdat <= rd_acc ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_icosoc_mod_eventbuf.sv
// tb/tb_icosoc_mod_eventbuf.sv - directed self-checking bench for icosoc_mod_eventbuf
module tb_icosoc_mod_eventbuf;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic [7:0]  io_in;
  logic [31:0] timestamp;
  logic        nonempty;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [15:0] A_CTRL  = 16'h00;
  localparam logic [15:0] A_MASK  = 16'h04;
  localparam logic [15:0] A_STAT  = 16'h08;
  localparam logic [15:0] A_HTS   = 16'h0C;
  localparam logic [15:0] A_HDAT  = 16'h10;
  localparam logic [15:0] A_DROPS = 16'h14;

  icosoc_mod_eventbuf #(.IO_WIDTH(8), .DEPTH_LOG2(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ctrl_wr   (ctrl_wr),
    .ctrl_rd   (ctrl_rd),
    .ctrl_addr (ctrl_addr),
    .ctrl_wdat (ctrl_wdat),
    .ctrl_rdat (ctrl_rdat),
    .ctrl_done (ctrl_done),
    .io_in     (io_in),
    .timestamp (timestamp),
    .nonempty  (nonempty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    timestamp = timestamp + 32'd1;
  endtask

  task automatic toggle_step();
    io_in = io_in ^ 8'h01;
    step();
  endtask

  task automatic reg_read(input logic [15:0] a, input bit tog, output logic [31:0] d);
    ctrl_rd   = 1'b1;
    ctrl_addr = a;
    if (tog) io_in = io_in ^ 8'h01;
    step();
    check("rd_done", 32'(ctrl_done), 32'd1);
    d = ctrl_rdat;
    ctrl_rd = 1'b0;
    step();
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [31:0] v, input bit tog);
    ctrl_wr   = 4'hF;
    ctrl_addr = a;
    ctrl_wdat = v;
    if (tog) io_in = io_in ^ 8'h01;
    step();
    check("wr_done", 32'(ctrl_done), 32'd1);
    ctrl_wr = 4'h0;
    step();
  endtask

  task automatic expect_reg(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, 1'b0, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    resetn = 1'b0; ctrl_wr = 4'h0; ctrl_rd = 1'b0; ctrl_addr = 16'h0;
    ctrl_wdat = 32'h0; io_in = 8'h00; timestamp = 32'd0;
    repeat (3) step();
    resetn = 1'b1;
    step();

    // Reset state
    check("rst_nonempty", 32'(nonempty), 32'd0);
    check("rst_done", 32'(ctrl_done), 32'd0);
    check("rst_rdat", ctrl_rdat, 32'd0);
    expect_reg("rst_ctrl", A_CTRL, 32'h0);
    expect_reg("rst_mask", A_MASK, 32'h0);
    expect_reg("rst_status", A_STAT, 32'h0001_0000);
    expect_reg("rst_head_ts", A_HTS, 32'h0);
    expect_reg("rst_head_data", A_HDAT, 32'h0);
    expect_reg("rst_drops", A_DROPS, 32'h0);
    expect_reg("unmapped", 16'h0018, 32'h0);
    check("rdat_idle", ctrl_rdat, 32'd0);

    // Single masked edge; unmasked edge ignored
    reg_write(A_MASK, 32'h01, 1'b0);
    reg_write(A_CTRL, 32'h01, 1'b0);
    expect_reg("mask_rb", A_MASK, 32'h01);
    timestamp = 32'd100; io_in = 8'h01; step();
    io_in = 8'h03; step();
    check("one_nonempty", 32'(nonempty), 32'd1);
    expect_reg("one_status", A_STAT, 32'h0000_0001);
    expect_reg("one_head_ts", A_HTS, 32'd100);
    expect_reg("one_head_data", A_HDAT, 32'h01);
    expect_reg("one_status_after", A_STAT, 32'h0001_0000);
    check("one_nonempty_after", 32'(nonempty), 32'd0);

    // Enabling with a stable input gives no spurious record
    reg_write(A_CTRL, 32'h00, 1'b0);
    io_in = 8'hFF; step(); step();
    reg_write(A_CTRL, 32'h01, 1'b0);
    step();
    expect_reg("en_stable_status", A_STAT, 32'h0001_0000);
    timestamp = 32'd200; io_in = 8'hFE; step();
    expect_reg("en_head_ts", A_HTS, 32'd200);
    expect_reg("en_head_data", A_HDAT, 32'hFE);

    // Overflow: 34 edges into 32 slots, then drain across the pointer wrap
    timestamp = 32'd1000;
    for (int i = 0; i < 34; i++) toggle_step();
    expect_reg("ovf_status", A_STAT, 32'h0006_0020);
    expect_reg("ovf_drops", A_DROPS, 32'd2);
    for (int i = 0; i < 32; i++) begin
      expect_reg($sformatf("drain_ts_%0d", i), A_HTS, 32'd1000 + 32'(i));
      expect_reg($sformatf("drain_data_%0d", i), A_HDAT, (i % 2 == 0) ? 32'hFF : 32'hFE);
    end
    expect_reg("drained_status", A_STAT, 32'h0005_0000);
    reg_write(A_CTRL, 32'h03, 1'b0);
    expect_reg("clr_status", A_STAT, 32'h0001_0000);
    expect_reg("clr_drops", A_DROPS, 32'd0);
    expect_reg("clr_ctrl", A_CTRL, 32'h01);

    // Event coincident with a pop at level 5
    timestamp = 32'd2000;
    for (int i = 0; i < 5; i++) toggle_step();
    expect_reg("lvl5_status", A_STAT, 32'h0000_0005);
    reg_read(A_HDAT, 1'b1, d);
    check("pop_evt_data", d, 32'hFF);
    expect_reg("pop_evt_status", A_STAT, 32'h0000_0005);
    expect_reg("pop_evt_head_ts", A_HTS, 32'd2001);

    // Event coincident with clear
    reg_write(A_CTRL, 32'h03, 1'b1);
    expect_reg("clr_evt_status", A_STAT, 32'h0001_0000);
    expect_reg("clr_evt_drops", A_DROPS, 32'd0);

    // Reset mid-burst at level 7
    for (int i = 0; i < 7; i++) toggle_step();
    expect_reg("lvl7_status", A_STAT, 32'h0000_0007);
    resetn = 1'b0; step(); resetn = 1'b1; step();
    check("mid_rst_nonempty", 32'(nonempty), 32'd0);
    expect_reg("mid_rst_status", A_STAT, 32'h0001_0000);
    expect_reg("mid_rst_ctrl", A_CTRL, 32'h0);
    expect_reg("mid_rst_head_data", A_HDAT, 32'h0);
    reg_write(A_MASK, 32'h01, 1'b0);
    toggle_step(); toggle_step();
    expect_reg("dis_status", A_STAT, 32'h0001_0000);
    reg_write(A_CTRL, 32'h01, 1'b0);
    timestamp = 32'd3000; toggle_step();
    expect_reg("reen_status", A_STAT, 32'h0000_0001);
    expect_reg("reen_head_ts", A_HTS, 32'd3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/icosoc_mod_eventbuf.md
# icosoc_mod_eventbuf

- Downstream stage of the trigger-recorder input sampler.
- Watches the already-synchronized IO sample vector and the free-running 32-bit cycle counter.
- On every enabled pin change, pushes a {timestamp, pin value} record into an on-chip FIFO.
- The CPU drains records over the standard icosoc ctrl bus, so short bursts of pin edges are captured losslessly without CPU polling at edge rate.

## Interface
- IO_WIDTH, 8: width of monitored pin vector (1..32)
- DEPTH_LOG2, 5: FIFO depth = 2^DEPTH_LOG2 records (32)
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- ctrl_wr  in  4  byte write strobes; any set bit = write
- ctrl_rd  in  1  read request
- ctrl_addr  in  16  register byte offset
- ctrl_wdat  in  32  write data
- ctrl_rdat  out  32  read data, valid in the cycle ctrl_done is high
- ctrl_done  out  1  one-cycle access acknowledge
- io_in  in  IO_WIDTH  synchronized pin samples from the upstream sampler
- timestamp  in  32  upstream free-running cycle counter
- nonempty  out  1  high while FIFO level > 0 (interrupt source)

## Operation
- Reset: all outputs 0; CTRL, MASK, drop count, overflow flag, pointers, level = 0; prev = 0.
- prev <= io_in every cycle, regardless of enable, so enabling never produces a spurious event.
- Event condition: CTRL.enable && ((io_in ^ prev) & MASK) != 0.
- On event:
  - Not full: push record {timestamp, io_in} sampled at the same edge.
  - Full: record dropped; overflow flag set; drop count += 1, saturating at 0xFFFF.
- Full is judged on the pre-edge level. A pop in the same cycle does not rescue a push into a full FIFO.
- Register map (32-bit, unmapped reads return 0, unmapped writes ignored):
  - 0x00 CTRL rw: bit0 enable; bit1 clear (write 1: flush FIFO, zero drop count and overflow; self-clearing, reads 0).
  - 0x04 MASK rw: IO_WIDTH bits, zero-extended.
  - 0x08 STATUS ro: [15:0] level, [16] empty, [17] full, [18] overflow sticky.
  - 0x0C HEAD_TS ro: timestamp of head record; no pop; 0 when empty.
  - 0x10 HEAD_DATA ro: pin value of head record, zero-extended; pops the head; 0 and no pop when empty.
  - 0x14 DROPS ro: [15:0] drop count.
- Push and pop in the same cycle: both occur; level unchanged.
- Clear and event in the same cycle: clear wins; the event is discarded, not counted.
- Pointer arithmetic: DEPTH_LOG2-bit pointers wrap modulo depth; level is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- Mid-operation reset: FIFO contents become don't-care; level 0, so no stale record is readable.

## Timing
- ctrl handshake:
  - An access is accepted when (ctrl_rd or |ctrl_wr) and ctrl_done was low in the previous cycle.
  - ctrl_done goes high at the next edge for exactly one cycle; ctrl_rdat is valid in that cycle and 0 otherwise.
  - A request still held during the done cycle is not re-executed.
- Pop takes effect at the same edge that drives HEAD_DATA onto ctrl_rdat.
- Event latency: pin change seen at edge N is stored at edge N. STATUS level and nonempty reflect it from edge N (visible to an access issued in cycle N+1).
- Register writes take effect at the done edge. Events from edge done+1 use the new MASK/enable.
- FIFO storage is a read-registered array (maps to SB_RAM40_4K). The head record is prefetched so HEAD_TS/HEAD_DATA need no extra wait cycle.

## Structure
- Shared package/header icosoc_eventbuf_pkg:
  - register offsets (REG_CTRL..REG_DROPS)
  - CTRL/STATUS bit positions
  - record width constant (32 + IO_WIDTH)
- Sub-module icosoc_eventbuf_fifo:
  - generic sync FIFO (WIDTH, DEPTH_LOG2 parameters)
  - push/pop/flush inputs; full/empty/level outputs; first-word-fall-through head output
- Top module holds edge detection, drop counter and ctrl decode.

## Test plan
- Reset then read all registers -> CTRL=0, MASK=0, STATUS=0x00010000, HEAD_TS=0, HEAD_DATA=0, DROPS=0, nonempty=0.
- MASK=0x01, enable, toggle io_in[0] 0->1 at timestamp 100, toggle io_in[1] -> exactly one record: HEAD_TS=100, HEAD_DATA=0x01; DATA read pops; STATUS returns to empty.
- Enable with io_in=0xFF already stable -> no record; next change of a masked bit -> record with its timestamp.
- 34 masked edges without reads -> level 32, full=1, overflow=1, DROPS=2; drained records have increasing timestamps matching the first 32 edges, with correct wrap-around.
- Event coincident with HEAD_DATA pop at level 5 -> level stays 5; event coincident with clear -> level 0, DROPS 0.
- Reset asserted mid-burst at level 7 -> level 0, nonempty 0, enable 0; later events are not recorded until re-enabled.
